// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared scan-code constants, ASCII codes for the arrow keys,
//                receiver state type and a majority-vote helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Scan-code set 2 prefix and modifier codes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Control codes emitted for the extended arrow keys
    localparam logic [7:0] ASCII_UP    = 8'h01;
    localparam logic [7:0] ASCII_DOWN  = 8'h02;
    localparam logic [7:0] ASCII_LEFT  = 8'h03;
    localparam logic [7:0] ASCII_RIGHT = 8'h04;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // 2-of-3 vote used to reject single-sample glitches on the PS/2 lines
    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 line conditioning (2-flop sync + 3-sample majority),
//                11-bit frame receiver with odd-parity check and idle timeout.
//                Emits a one-cycle byte_valid pulse per accepted byte.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [2:0]    clk_hist;
    logic [2:0]    dat_hist;
    logic          clk_filt;
    logic          dat_filt;
    logic          clk_filt_d;
    logic          fall;
    logic          timeout;
    logic [TW-1:0] tmo_cnt;

    rx_state_t     state, state_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          par_bit, par_nx;
    logic          valid_nx;
    logic [7:0]    data_nx;

    // Synchronize and majority-filter both lines; idle level is high
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_hist   <= 3'b111;
            dat_hist   <= 3'b111;
            clk_filt   <= 1'b1;
            dat_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_hist   <= {clk_hist[1:0], clk_sync[1]};
            dat_hist   <= {dat_hist[1:0], dat_sync[1]};
            clk_filt   <= majority3(clk_hist);
            dat_filt   <= majority3(dat_hist);
            clk_filt_d <= clk_filt;
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign timeout = (state != IDLE) && !fall && (tmo_cnt == TIMEOUT_LIMIT);

    // Idle timer: restarts on every PS/2 clock fall, only runs inside a frame
    always_ff @(posedge clock) begin
        if (reset || fall || state == IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TIMEOUT_LIMIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Receiver state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shreg      <= shreg_nx;
            par_bit    <= par_nx;
            byte_valid <= valid_nx;
            byte_data  <= data_nx;
        end
    end

    // Frame sequencing: one step per filtered clock fall, abort on timeout
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        par_nx     = par_bit;
        valid_nx   = 1'b0;
        data_nx    = byte_data;
        if (timeout) begin
            state_nx = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_filt) begin
                        state_nx   = DATA;
                        bit_cnt_nx = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nx   = {dat_filt, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = PARITY;
                    end
                end
                PARITY: begin
                    par_nx   = dat_filt;
                    state_nx = STOP;
                end
                STOP: begin
                    state_nx = IDLE;
                    // Odd parity means XOR over data plus parity bit is 1
                    if (dat_filt && (^{shreg, par_bit})) begin
                        valid_nx = 1'b1;
                        data_nx  = shreg;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard
//  Description : PS/2 keyboard front end. Tracks E0/F0 prefixes and shift
//                state, maps set-2 make codes to ASCII and strobes kdone.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       kdone,
    output logic [7:0] ascii
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ext;
    logic       brk;
    logic       shift;
    logic       map_hit;
    logic [7:0] map_char;
    logic       letter_hit;
    logic [7:0] letter;
    logic       digit_hit;
    logic [3:0] digit;
    logic [7:0] digit_char;

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    // Scan code to ASCII lookup for the current prefix/shift context
    always_comb begin
        map_hit    = 1'b0;
        map_char   = 8'h00;
        letter_hit = 1'b1;
        letter     = 8'h00;
        digit_hit  = 1'b1;
        digit      = 4'd0;
        digit_char = 8'h00;

        case (byte_data)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;  8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;  8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;  8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;  8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            default: letter_hit = 1'b0;
        endcase

        case (byte_data)
            8'h45: digit = 4'd0;  8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;  8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;  8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;  8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;  8'h46: digit = 4'd9;
            default: digit_hit = 1'b0;
        endcase

        if (shift) begin
            case (digit)
                4'd0: digit_char = 8'h29;  4'd1: digit_char = 8'h21;
                4'd2: digit_char = 8'h40;  4'd3: digit_char = 8'h23;
                4'd4: digit_char = 8'h24;  4'd5: digit_char = 8'h25;
                4'd6: digit_char = 8'h5E;  4'd7: digit_char = 8'h26;
                4'd8: digit_char = 8'h2A;  4'd9: digit_char = 8'h28;
                default: digit_char = 8'h00;
            endcase
        end else begin
            digit_char = 8'h30 + {4'd0, digit};
        end

        if (ext) begin
            case (byte_data)
                8'h75: begin map_hit = 1'b1; map_char = ASCII_UP;    end
                8'h72: begin map_hit = 1'b1; map_char = ASCII_DOWN;  end
                8'h6B: begin map_hit = 1'b1; map_char = ASCII_LEFT;  end
                8'h74: begin map_hit = 1'b1; map_char = ASCII_RIGHT; end
                default: map_hit = 1'b0;
            endcase
        end else if (letter_hit) begin
            map_hit  = 1'b1;
            map_char = shift ? (letter - 8'h20) : letter;
        end else if (digit_hit) begin
            map_hit  = 1'b1;
            map_char = digit_char;
        end else begin
            case (byte_data)
                8'h29: begin map_hit = 1'b1; map_char = 8'h20; end
                8'h5A: begin map_hit = 1'b1; map_char = 8'h0D; end
                8'h66: begin map_hit = 1'b1; map_char = 8'h08; end
                8'h76: begin map_hit = 1'b1; map_char = 8'h1B; end
                8'h0D: begin map_hit = 1'b1; map_char = 8'h09; end
                default: map_hit = 1'b0;
            endcase
        end
    end

    // Prefix/shift tracking and character emit on each accepted byte
    always_ff @(posedge clock) begin
        if (reset) begin
            kdone <= 1'b0;
            ascii <= 8'h00;
            ext   <= 1'b0;
            brk   <= 1'b0;
            shift <= 1'b0;
        end else begin
            kdone <= 1'b0;
            if (byte_valid) begin
                if (byte_data == SC_EXT) begin
                    ext <= 1'b1;
                end else if (byte_data == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!ext && (byte_data == SC_LSHIFT || byte_data == SC_RSHIFT)) begin
                        shift <= !brk;
                    end else if (!brk && map_hit) begin
                        kdone <= 1'b1;
                        ascii <= map_char;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard
//  Description : Self-checking bench for ps2_keyboard. Frames are bit-banged
//                on the PS/2 lines; expected characters go into a queue and
//                are popped as kdone pulses appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard;

    localparam int HALF = 10;   // PS/2 half bit period in system clocks
    localparam int GAP  = 40;   // idle clocks between bytes

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       kdone;
    logic [7:0] ascii;

    int         tests_run = 0;
    int         failed    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_c;
    logic       prev_kdone = 1'b0;

    // Timeout becomes 1 MHz / 1e6 * 200 = 200 cycles
    ps2_keyboard #(
        .CLK_HZ     (1000000),
        .TIMEOUT_US (200)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .kdone   (kdone),
        .ascii   (ascii)
    );

    always #5 clock = ~clock;

    // Scoreboard: every kdone pulse must match the oldest expected character
    always @(negedge clock) begin
        if (kdone === 1'b1) begin
            tests_run++;
            if (prev_kdone === 1'b1) begin
                failed++;
                $display("FAIL kdone_consecutive: kdone high two cycles, required single pulse");
            end
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL kdone_unexpected: got pulse ascii=%02h, required no pulse", ascii);
            end else begin
                exp_c = exp_q.pop_front();
                if (ascii !== exp_c) begin
                    failed++;
                    $display("FAIL kdone_ascii: got %02h, required %02h", ascii, exp_c);
                end
            end
        end
        prev_kdone = kdone;
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (GAP) @(posedge clock);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
        ps2_dat = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (kdone !== 1'b0 || ascii !== 8'h00) begin
            failed++;
            $display("FAIL reset_hold: kdone=%b ascii=%02h, required 0/00", kdone, ascii);
        end
        reset = 1'b0;
        repeat (10) @(negedge clock);
        tests_run++;
        if (kdone !== 1'b0 || ascii !== 8'h00) begin
            failed++;
            $display("FAIL reset_release: kdone=%b ascii=%02h, required 0/00", kdone, ascii);
        end
    endtask

    task automatic test_make_break();
        exp_q.push_back(8'h61);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        tests_run++;
        if (exp_q.size() != 0 || ascii !== 8'h61) begin
            failed++;
            $display("FAIL make_break: pending=%0d ascii=%02h, required 0/61", exp_q.size(), ascii);
        end
    endtask

    task automatic test_shift_letters();
        send_byte(8'h12, 1'b0);
        exp_q.push_back(8'h41);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back(8'h61);
        send_byte(8'h1C, 1'b0);
        // right shift and another letter
        send_byte(8'h59, 1'b0);
        exp_q.push_back(8'h5A);
        send_byte(8'h1A, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h59, 1'b0);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL shift_letters: %0d pulses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_digits_ext();
        send_byte(8'h12, 1'b0);
        exp_q.push_back(8'h21);
        send_byte(8'h16, 1'b0);
        exp_q.push_back(8'h40);
        send_byte(8'h1E, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        exp_q.push_back(8'h30);
        send_byte(8'h45, 1'b0);
        exp_q.push_back(8'h0D);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hE0, 1'b0);
        exp_q.push_back(8'h01);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        exp_q.push_back(8'h04);
        send_byte(8'h74, 1'b0);
        // unmapped code
        send_byte(8'h0E, 1'b0);
        tests_run++;
        if (exp_q.size() != 0 || ascii !== 8'h04) begin
            failed++;
            $display("FAIL digits_ext: pending=%0d ascii=%02h, required 0/04", exp_q.size(), ascii);
        end
    endtask

    task automatic test_bad_parity();
        send_byte(8'h1C, 1'b1);
        tests_run++;
        if (ascii !== 8'h04) begin
            failed++;
            $display("FAIL bad_parity: ascii=%02h, required 04 (byte dropped)", ascii);
        end
        exp_q.push_back(8'h62);
        send_byte(8'h32, 1'b0);
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL after_bad_parity: %0d pulses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        send_partial(8'h55, 5);
        repeat (300) @(posedge clock);
        exp_q.push_back(8'h20);
        send_byte(8'h29, 1'b0);
        tests_run++;
        if (exp_q.size() != 0 || ascii !== 8'h20) begin
            failed++;
            $display("FAIL timeout: pending=%0d ascii=%02h, required 0/20", exp_q.size(), ascii);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hF0, 1'b0);
        send_partial(8'h1C, 4);
        ps2_dat = 1'b1;
        repeat (HALF / 2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if (kdone !== 1'b0 || ascii !== 8'h00) begin
            failed++;
            $display("FAIL reset_mid_frame: kdone=%b ascii=%02h, required 0/00", kdone, ascii);
        end
        repeat (GAP) @(posedge clock);
        exp_q.push_back(8'h61);
        send_byte(8'h1C, 1'b0);
        tests_run++;
        if (exp_q.size() != 0 || ascii !== 8'h61) begin
            failed++;
            $display("FAIL after_reset: pending=%0d ascii=%02h, required 0/61", exp_q.size(), ascii);
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_shift_letters();
        test_digits_ext();
        test_bad_parity();
        test_timeout();
        test_reset_mid_frame();
        repeat (20) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
# ps2_keyboard

- Upstream PS/2 keyboard front end: samples the raw PS/2 clock/data lines and deserializes scan-code set 2 frames.
- Tracks prefix and shift state, converts make codes to ASCII, and emits a one-cycle strobe with the character.
- Outputs drive `p_kdone`/`p_ascii` of the I/O port block, which latches the character and raises the "key received" flag.

## Interface
- `CLK_HZ`, 25000000: system clock frequency.
- `TIMEOUT_US`, 2000: idle time after which a partial frame is discarded.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `ps2_dat`  in  1  raw PS/2 data line, asynchronous.
- `kdone`  out  1  one-cycle pulse: `ascii` holds a new character.
- `ascii`  out  8  ASCII code of last accepted key; stable until next `kdone`.

## Operation
- Input conditioning:
  - Both lines pass a 2-flop synchronizer, then a 3-sample majority filter.
  - A falling edge of filtered `ps2_clk` samples filtered `ps2_dat`.
- Frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1 (11 bits).
- Receiver FSM:
  - States: IDLE, DATA (8 bits), PARITY, STOP.
  - IDLE → DATA on a sampled 0. A sampled 1 in IDLE is ignored.
  - STOP: byte accepted only if parity is odd and stop = 1. Otherwise it is silently dropped. Either way → IDLE.
- Timeout: a cycle counter restarts on every `ps2_clk` falling edge. If it reaches `CLK_HZ/1000000*TIMEOUT_US` outside IDLE, the FSM returns to IDLE and discards partial bits.
- Decoder, per accepted byte:
  - `E0` sets `ext`. `F0` sets `brk`. Neither emits anything.
  - Any other byte is a code. Both flags clear after it is processed.
  - Codes `12`/`59` (L/R shift) with `ext=0`: shift ← !brk. No emit.
  - Any code with `brk=1`: no emit.
  - Make code with `ext=0`:
    - Letters `1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A` → `a`..`z` (`61`..`7A`); minus `20` when shift=1.
    - Digits `45 16 1E 26 25 2E 36 3D 3E 46` → `0`..`9` (`30`..`39`). With shift=1 they give `)!@#$%^&*(`.
    - `29`→`20` (space), `5A`→`0D` (enter), `66`→`08` (backspace), `76`→`1B` (esc), `0D`→`09` (tab).
  - Make code with `ext=1`: `75`→`01` up, `72`→`02` down, `6B`→`03` left, `74`→`04` right.
  - Unmapped codes produce no `kdone`.
- Emit: `ascii` ← mapped code and `kdone` ← 1 in the same cycle; `kdone` returns to 0 the next cycle.

## Timing
- Reset values:
  - Outputs: `kdone`=0, `ascii`=`00`.
  - Internal: FSM=IDLE; `ext`=`brk`=shift=0; timeout counter=0.
- Latency: the synchronizer plus filter add 4–5 cycles after the raw `ps2_clk` fall. `kdone` asserts exactly 2 cycles after the stop-bit sample: cycle 1 latches the byte, cycle 2 decodes and registers.
- `kdone` is never asserted on consecutive cycles; PS/2 byte spacing (≥ ~1 ms) guarantees this.
- Reset mid-frame: partial frame and all flags are discarded; the next start bit begins a clean frame.
- Reset wins over a simultaneous emit: `kdone` stays 0.
- Flag life:
  - A timeout clears receive state only.
  - `ext`/`brk`/shift persist across timeouts and clear only on reset or after a code.
- Data lines are never driven: receive-only, no host-to-device commands.

## Structure
- Shared package `ps2_pkg`:
  - Constants `SC_EXT=8'hE0`, `SC_BRK=8'hF0`, `SC_LSHIFT=8'h12`, `SC_RSHIFT=8'h59`.
  - ASCII constants for the arrow codes `01`–`04`.
- One sub-module `ps2_rx`: synchronizer, filter, frame FSM, timeout. Outputs `byte_valid` (1-cycle pulse) and `byte_data[7:0]`.
- Top-level `ps2_keyboard` holds the decoder flags and the combinational scancode→ASCII case.

## Test plan
- Frame `1C` → `kdone` pulse, `ascii`=`61`; then `F0 1C` → no pulse, `ascii` stays `61`.
- `12`, `1C`, `F0 12`, `1C` → two pulses, `ascii`=`41` then `61`.
- `12`, `16` → `ascii`=`21` (`!`). `E0 75` → `ascii`=`01`. `E0 F0 75` → no pulse.
- Frame `1C` with even parity → no pulse. Next valid `32` → `ascii`=`62`.
- Stop after 5 data bits, idle > 2 ms, then send `29` → single pulse, `ascii`=`20`.
- Assert `reset` during bit 4 of `1C` (after a prior `F0`) → outputs `00`/0. A following `1C` → `ascii`=`61` (`brk` cleared).
